// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, one full-adder cell, LSB first, with a
//               start/busy/done handshake and Cout/OverFlow/ZeroFlag flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             OverFlow,
    output logic             ZeroFlag
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:1] r_ss;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;

    // The single full-adder cell; r_c at the last bit is the carry into the MSB.
    assign w_s        = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_cout     = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
    assign w_sum_next = {w_s, r_ss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_ss     <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            Cout     <= 1'b0;
            OverFlow <= 1'b0;
            ZeroFlag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= A;
                        r_sb    <= B;
                        r_ss    <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_BUSY;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_ss <= w_sum_next[WIDTH-1:1];
                    r_sa <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb <= {1'b0, r_sb[WIDTH-1:1]};
                    r_c  <= w_cout;
                    if (r_cnt == C_LAST) begin
                        result   <= w_sum_next;
                        Cout     <= w_cout;
                        OverFlow <= r_c ^ w_cout;
                        ZeroFlag <= (w_sum_next == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       Cout;
    logic       OverFlow;
    logic       ZeroFlag;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .Cout     (Cout),
        .OverFlow (OverFlow),
        .ZeroFlag (ZeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation, then wait (bounded) for done; reports edges from
    // the accepting edge to done and whether busy was ever low while waiting.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output bit busy_ok);
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        #12;
        vectors++;
        if ({busy, done, result, Cout, OverFlow, ZeroFlag} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h C=%b V=%b Z=%b, want all 0",
                     busy, done, result, Cout, OverFlow, ZeroFlag);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        run_op(8'h05, 8'h03, lat, bok);
        vectors++;
        if (lat !== 8 || !bok) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges busy_ok=%b, want 8 edges busy_ok=1", lat, bok);
        end
        vectors++;
        if ({result, Cout, OverFlow, ZeroFlag} !== {8'h08, 3'b000}) begin
            miscompares++;
            $display("FAIL basic_result: got %h C=%b V=%b Z=%b, want 08 C=0 V=0 Z=0",
                     result, Cout, OverFlow, ZeroFlag);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_at_done: got %b, want 0", busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%b after one cycle, want 0", done);
        end
    endtask

    task automatic test_carry();
        int lat;
        bit bok;
        run_op(8'hFF, 8'h01, lat, bok);
        vectors++;
        if (lat !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h00, 3'b101}) begin
            miscompares++;
            $display("FAIL carry_ff_01: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 00 C=1 V=0 Z=1",
                     lat, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
        run_op(8'h7F, 8'h01, lat, bok);
        vectors++;
        if (lat !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h80, 3'b010}) begin
            miscompares++;
            $display("FAIL overflow_7f_01: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 80 C=0 V=1 Z=0",
                     lat, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
    endtask

    task automatic test_hold();
        int lat;
        bit bok;
        run_op(8'h80, 8'h80, lat, bok);
        vectors++;
        if (lat !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h00, 3'b111}) begin
            miscompares++;
            $display("FAIL sum_80_80: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 00 C=1 V=1 Z=1",
                     lat, result, Cout, OverFlow, ZeroFlag);
        end
        A = 8'h3C;
        B = 8'h11;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({busy, done, result, Cout, OverFlow, ZeroFlag} !== {2'b00, 8'h00, 3'b111}) begin
                miscompares++;
                $display("FAIL idle_hold[%0d]: got busy=%b done=%b %h C=%b V=%b Z=%b, want 0 0 00 1 1 1",
                         i, busy, done, result, Cout, OverFlow, ZeroFlag);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bit held;
        start = 1'b1;
        A     = 8'h10;
        B     = 8'h20;
        tick();
        start = 1'b0;
        n     = 0;
        held  = 1'b1;
        while (!done && n < 20) begin
            if (result !== 8'h00 || {Cout, OverFlow, ZeroFlag} !== 3'b111) held = 1'b0;
            if (n == 2) begin
                start = 1'b1;
                A     = 8'hAA;
                B     = 8'h55;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL busy_hold: outputs changed during BUSY, want 00 C=1 V=1 Z=1 held");
        end
        vectors++;
        if (n !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h30, 3'b000}) begin
            miscompares++;
            $display("FAIL start_ignored: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 30 C=0 V=0 Z=0",
                     n, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int  lat;
        bit  bok;
        bit  spurious;
        start = 1'b1;
        A     = 8'h01;
        B     = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, result, Cout, OverFlow, ZeroFlag} !== 13'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b %h C=%b V=%b Z=%b, want all 0",
                     busy, done, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
        rst_n    = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        vectors++;
        if (spurious) begin
            miscompares++;
            $display("FAIL abort_no_done: got busy/done activity after reset, want none");
        end
        run_op(8'h02, 8'h02, lat, bok);
        vectors++;
        if (lat !== 8 || !bok || {result, Cout, OverFlow, ZeroFlag} !== {8'h04, 3'b000}) begin
            miscompares++;
            $display("FAIL after_reset: got lat=%0d busy_ok=%b %h C=%b V=%b Z=%b, want lat=8 1 04 C=0 V=0 Z=0",
                     lat, bok, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start = 1'b1;
        A     = 8'h0F;
        B     = 8'hF1;
        tick();
        A = 8'h12;
        B = 8'h34;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h00, 3'b101}) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 00 C=1 V=0 Z=1",
                     n, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 8 || {result, Cout, OverFlow, ZeroFlag} !== {8'h46, 3'b000}) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d %h C=%b V=%b Z=%b, want lat=8 46 C=0 V=0 Z=0",
                     n, result, Cout, OverFlow, ZeroFlag);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_carry();
        test_hold();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
